// File: rtl/pin_id_tx_sched.sv
// Round-robin scheduler sharing one 8N1 serial identification line among N_REQ requesters.
// Each granted requester has its 4-character name sent MSB-character first, followed by an idle-high gap.
module pin_id_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  name_flat,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 busy,
    output logic                 tx_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CPB_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [CPB_W-1:0] CPB_LAST = CPB_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               tx_q, tx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [31:0]        name_q, name_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [CPB_W-1:0]   cpb_cnt_q, cpb_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               tail_q, tail_d;

    logic [IDX_W-1:0]   sel_c;
    logic [IDX_W-1:0]   probe_idx;
    logic [31:0]        name_sel;
    int                 probe;

    // Rotating priority search; walking offsets downward leaves the nearest requester to rr_ptr as winner.
    always_comb begin
        sel_c     = rr_ptr_q;
        probe_idx = '0;
        probe     = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            probe = int'(rr_ptr_q) + i;
            if (probe >= N_REQ) probe = probe - N_REQ;
            probe_idx = IDX_W'(probe);
            if ((req & (N_REQ'(1) << probe_idx)) != '0) sel_c = probe_idx;
        end
    end

    always_comb begin
        name_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_c == IDX_W'(i)) name_sel = name_flat[32*i +: 32];
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        tx_d       = 1'b1;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        name_d     = name_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        cpb_cnt_d  = cpb_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tail_d     = tail_q;

        case (state_q)
            S_IDLE: begin
                if (req != '0) begin
                    state_d    = S_START;
                    grant_d    = N_REQ'(1) << sel_c;
                    sel_d      = sel_c;
                    name_d     = name_sel;
                    byte_idx_d = '0;
                    bit_cnt_d  = '0;
                    cpb_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    tail_d     = 1'b0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (cpb_cnt_q == CPB_LAST) begin
                    cpb_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    cpb_cnt_d = cpb_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                // {~byte_idx, bit_cnt} picks bit (8*(3-byte_idx) + bit_cnt): first char first, LSB first.
                tx_d = name_q[{~byte_idx_q, bit_cnt_q}];
                if (cpb_cnt_q == CPB_LAST) begin
                    cpb_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cpb_cnt_d = cpb_cnt_q + 1'b1;
                end
            end
            S_STOP, S_GAP: begin
                tx_d = 1'b1;
                if (tail_q) begin
                    // Frame end: the registered last bit has just left tx_out.
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    done_d   = grant_q;
                    tail_d   = 1'b0;
                    rr_ptr_d = (sel_q == IDX_LAST) ? '0 : sel_q + 1'b1;
                end else if (cpb_cnt_q != CPB_LAST) begin
                    cpb_cnt_d = cpb_cnt_q + 1'b1;
                end else begin
                    cpb_cnt_d = '0;
                    if (state_q == S_STOP) begin
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            state_d    = S_START;
                        end else if (GAP_BITS == 0) begin
                            byte_idx_d = '0;
                            tail_d     = 1'b1;
                        end else begin
                            byte_idx_d = '0;
                            gap_cnt_d  = '0;
                            state_d    = S_GAP;
                        end
                    end else if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        tail_d    = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            tx_q       <= 1'b1;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            name_q     <= '0;
            byte_idx_q <= '0;
            bit_cnt_q  <= '0;
            cpb_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            name_q     <= name_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            cpb_cnt_q  <= cpb_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tail_q     <= tail_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);
    assign tx_out = tx_q;

endmodule

// File: tb/tb_pin_id_tx_sched.sv
// Directed bench for pin_id_tx_sched: a 4-requester instance (CPB=1, GAP=24) and a
// single-requester instance (CPB=4, GAP=0) sharing clock and reset.
module tb_pin_id_tx_sched;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] name_flat;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic         tx_out;

    logic [0:0]   req_b;
    logic [31:0]  name_b;
    logic [0:0]   grant_b;
    logic [0:0]   done_b;
    logic         busy_b;
    logic         tx_b;

    int checks = 0;
    int errors = 0;

    pin_id_tx_sched #(.N_REQ(4), .CLKS_PER_BIT(1), .GAP_BITS(24)) dut (
        .clk(clk), .rst(rst), .req(req), .name_flat(name_flat),
        .grant(grant), .done(done), .busy(busy), .tx_out(tx_out)
    );

    pin_id_tx_sched #(.N_REQ(1), .CLKS_PER_BIT(4), .GAP_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .name_flat(name_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .tx_out(tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line level at frame position pos (0..39 = four 10-bit 8N1 bytes, beyond = idle high).
    function automatic logic exp_bit(input logic [31:0] nm, input int pos);
        int b;
        int r;
        logic [31:0] t;
        if (pos >= 40) return 1'b1;
        b = pos / 10;
        r = pos % 10;
        if (r == 0) return 1'b0;
        if (r == 9) return 1'b1;
        t = nm >> (8 * (3 - b) + r - 1);
        return t[0];
    endfunction

    // Called in the cycle grant rises; returns in the cycle done pulses (65 cycles later).
    task automatic run_frame(input int idx, input int chg_at, input logic [3:0] new_req,
                             input bit chg_name, input logic [31:0] new_name0);
        logic [31:0] nm;
        logic [3:0]  oh;
        nm = 32'(name_flat >> (32 * idx));
        oh = 4'b0001 << idx;
        check($sformatf("grant_rise_idx%0d", idx), grant, oh);
        check("busy_rise", busy, 1);
        check("tx_at_grant", tx_out, 1);
        for (int k = 1; k <= 64; k++) begin
            tick();
            check($sformatf("tx_idx%0d_c%0d", idx, k), tx_out, exp_bit(nm, k - 1));
            check($sformatf("grant_hold_c%0d", k), grant, oh);
            check($sformatf("done_quiet_c%0d", k), done, 0);
            if (k == chg_at) begin
                req = new_req;
                if (chg_name) name_flat[31:0] = new_name0;
            end
        end
        tick();
        check($sformatf("done_pulse_idx%0d", idx), done, oh);
        check("grant_drop", grant, 0);
        check("busy_drop", busy, 0);
        check("tx_after_frame", tx_out, 1);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        req_b     = 1'b0;
        name_flat = {"WXYZ", "PQ34", "CD56", "AB12"};
        name_b    = 32'hA5C3_0F81;

        // Reset state
        tick();
        tick();
        check("rst_tx", tx_out, 1);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_b_tx", tx_b, 1);
        check("rst_b_busy", busy_b, 0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_noreq_tx", tx_out, 1);
        check("idle_noreq_busy", busy, 0);
        check("idle_noreq_grant", grant, 0);

        // Test 1: "AB12" from requester 0; explicit first byte then full frame
        req = 4'b0001;
        tick();
        check("t1_grant", grant, 4'b0001);
        begin
            logic [9:0] a_bits;
            a_bits = 10'b1010000010;
            for (int k = 1; k <= 10; k++) begin
                tick();
                check($sformatf("t1_A_bit%0d", k), tx_out, a_bits[k-1]);
            end
            for (int k = 11; k <= 64; k++) begin
                tick();
                check($sformatf("t1_tx_c%0d", k), tx_out, exp_bit(32'h41423132, k - 1));
            end
        end
        tick();
        check("t1_done_c65", done, 4'b0001);
        check("t1_grant_drop", grant, 0);

        // Test 6: req0 still high -> regranted; mid-frame name change and req drop
        tick();
        run_frame(0, 20, 4'b0000, 1'b1, 32'h5A5A_5A5A);
        tick();
        check("t6_no_regrant", grant, 0);
        check("t6_done_once", done, 0);
        check("t6_idle", busy, 0);

        // Test 5: reset mid-DATA of byte 2 (rr_ptr=1 -> requester 1 served)
        req = 4'b0010;
        tick();
        check("t5_grant1", grant, 4'b0010);
        for (int k = 1; k <= 24; k++) begin
            tick();
            check($sformatf("t5_tx_c%0d", k), tx_out, exp_bit("CD56", k - 1));
        end
        rst = 1'b1;
        tick();
        check("t5_rst_tx", tx_out, 1);
        check("t5_rst_grant", grant, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        rst = 1'b0;
        req = 4'b1000;
        tick();
        run_frame(3, 5, 4'b0000, 1'b0, 32'h0);
        tick();
        check("t5_idle_after", busy, 0);

        // Test 2 and 3: all requesting from reset, then directed pointer cases
        rst = 1'b1;
        req = 4'b1111;
        name_flat[31:0] = "AB12";
        tick();
        rst = 1'b0;
        tick();
        run_frame(0, -1, 4'b0000, 1'b0, 32'h0);
        tick();
        run_frame(1, -1, 4'b0000, 1'b0, 32'h0);
        tick();
        run_frame(2, -1, 4'b0000, 1'b0, 32'h0);
        tick();
        run_frame(3, -1, 4'b0000, 1'b0, 32'h0);
        tick();
        run_frame(0, 10, 4'b0010, 1'b0, 32'h0);
        tick();
        run_frame(1, 10, 4'b0011, 1'b0, 32'h0);
        tick();
        run_frame(0, 10, 4'b0010, 1'b0, 32'h0);
        tick();
        run_frame(1, 10, 4'b1010, 1'b0, 32'h0);
        tick();
        run_frame(3, 10, 4'b0000, 1'b0, 32'h0);
        tick();
        check("t3_end_grant", grant, 0);
        check("t3_end_busy", busy, 0);

        // Test 4: CPB=4, GAP=0, single requester served back-to-back
        req_b = 1'b1;
        tick();
        check("t4_grant", grant_b, 1);
        check("t4_tx_at_grant", tx_b, 1);
        for (int k = 1; k <= 160; k++) begin
            tick();
            check($sformatf("t4_tx_c%0d", k), tx_b, exp_bit(32'hA5C3_0F81, (k - 1) / 4));
            check($sformatf("t4_done_quiet_c%0d", k), done_b, 0);
        end
        tick();
        check("t4_done_c161", done_b, 1);
        check("t4_grant_drop", grant_b, 0);
        check("t4_busy_drop", busy_b, 0);
        check("t4_tx_high", tx_b, 1);
        tick();
        check("t4_backtoback_grant", grant_b, 1);
        check("t4_done_cleared", done_b, 0);
        req_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
